mm6532_master: RTL and testbench

MM6532_MASTER -- requirements
Module: mm6532_master

---
 rtl/mm6532_pkg.sv | 32 +++
 rtl/mm6532_wdog.sv | 26 ++
 rtl/mm6532_master.sv | 167 ++++++++++++++++
 tb/tb_mm6532_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm6532_pkg.sv
// Shared encodings for the 6532-style bus master: opcodes, chip-select codes,
// fixed peripheral addresses and the controller state type.
package mm6532_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_TWAIT = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  localparam logic [1:0] CS_SEL   = 2'b01;
  localparam logic [1:0] CS_DESEL = 2'b10;

  localparam logic [6:0] IRQ_FLAG_ADDR = 7'h05;
  localparam logic [6:0] TIMER_BASE    = 7'h14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_TWRITE = 3'd2,
    ST_GAP    = 3'd3,
    ST_POLL   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Timer registers sit at 0x14..0x17 / 0x1C..0x1F; bit 3 picks the irq-enable bank.
  function automatic logic [6:0] timer_addr(input logic [6:0] a);
    return TIMER_BASE | {3'b000, a[3], 1'b0, a[1:0]};
  endfunction

endpackage

// File: rtl/mm6532_wdog.sv
// Saturating 16-bit timeout counter used while waiting on the timer flag.
module mm6532_wdog
  import mm6532_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= 16'h0000;
    end else if (en_i && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign expired_o = (cnt_q >= TIMEOUT);

endmodule

// File: rtl/mm6532_master.sv
// Command-driven bus master for a 6532 RAM/I-O/timer: single reads/writes and
// a timer-wait that loads the timer and polls the interrupt flag with a timeout.
module mm6532_master
  import mm6532_pkg::*;
#(
  parameter int unsigned POLL_GAP = 4,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic       clk_i,
  input  logic       res_i,
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; once raised, valid and its payload hold until that transfer.
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic       cmd_ram_i,
  input  logic [6:0] cmd_a_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic       r_w_o,
  output logic [1:0] cs_o,
  output logic       rs_n_o,
  output logic [6:0] a_o,
  output logic [7:0] d_out_o,
  input  logic [7:0] d_in_i,
  input  logic       irq_n_i,
  output logic [2:0] state_o
);

  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);

  state_e     state_q;
  logic       cmd_ready_q;
  logic       is_read_q;
  logic [7:0] gap_q;
  logic [7:0] poll_q;
  logic [7:0] poll_d;
  logic       accept;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  assign accept = (state_q == ST_IDLE) && cmd_valid_i && cmd_ready_q;
  assign poll_d = (poll_q == 8'hFF) ? poll_q : poll_q + 8'h01;
  assign wd_clr = accept && (op_e'(cmd_op_i) == OP_TWAIT);
  assign wd_en  = (state_q == ST_TWRITE) || (state_q == ST_GAP) || (state_q == ST_POLL);

  mm6532_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (res_i),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      is_read_q   <= 1'b0;
      gap_q       <= 8'h00;
      poll_q      <= 8'h00;
      cs_o        <= CS_DESEL;
      r_w_o       <= 1'b0;
      rs_n_o      <= 1'b1;
      a_o         <= 7'h00;
      d_out_o     <= 8'h00;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 8'h00;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready_q <= 1'b0;
            is_read_q   <= cmd_op_i[0];
            case (op_e'(cmd_op_i))
              OP_WRITE, OP_READ: begin
                state_q <= ST_ACCESS;
                cs_o    <= CS_SEL;
                a_o     <= cmd_a_i;
                rs_n_o  <= ~cmd_ram_i;
                r_w_o   <= ~cmd_op_i[0];
                d_out_o <= cmd_data_i;
              end
              OP_TWAIT: begin
                state_q <= ST_TWRITE;
                cs_o    <= CS_SEL;
                a_o     <= timer_addr(cmd_a_i);
                rs_n_o  <= 1'b1;
                r_w_o   <= 1'b1;
                d_out_o <= cmd_data_i;
                poll_q  <= 8'h00;
              end
              default: begin
                state_q     <= ST_RESP;
                rsp_valid_o <= 1'b1;
                rsp_data_o  <= 8'h00;
                rsp_err_o   <= 1'b1;
              end
            endcase
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          state_q     <= ST_RESP;
          cs_o        <= CS_DESEL;
          r_w_o       <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_data_o  <= is_read_q ? d_in_i : 8'h00;
          rsp_err_o   <= 1'b0;
        end
        ST_TWRITE: begin
          state_q <= ST_GAP;
          cs_o    <= CS_DESEL;
          r_w_o   <= 1'b0;
          gap_q   <= GAP_LOAD;
        end
        ST_GAP: begin
          if (gap_q == 8'h00) begin
            state_q <= ST_POLL;
            cs_o    <= CS_SEL;
            r_w_o   <= 1'b0;
            rs_n_o  <= 1'b1;
            a_o     <= IRQ_FLAG_ADDR;
          end else begin
            gap_q <= gap_q - 8'h01;
          end
        end
        ST_POLL: begin
          cs_o   <= CS_DESEL;
          poll_q <= poll_d;
          // A raised flag wins over an expired timeout in the same poll.
          if (d_in_i[7] || !irq_n_i || wd_expired) begin
            state_q     <= ST_RESP;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= poll_d;
            rsp_err_o   <= !(d_in_i[7] || !irq_n_i);
          end else begin
            state_q <= ST_GAP;
            gap_q   <= GAP_LOAD;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cs_o    <= CS_DESEL;
          r_w_o   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mm6532_master.sv
// Bench for mm6532_master: a RAM/IO peripheral model on the bus, a command
// driver with a reference model feeding expected-queues, and decoupled monitors.
module tb_mm6532_master;

  localparam int G = 4;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_ram = 1'b0;
  logic [6:0] cmd_a = 7'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       r_w;
  logic [1:0] cs;
  logic       rs_n;
  logic [6:0] a;
  logic [7:0] d_out;
  logic [7:0] d_in;
  logic       irq_n;
  logic [2:0] state;

  mm6532_master #(.POLL_GAP(G), .TIMEOUT(16'(T))) dut (
    .clk_i(clk), .res_i(res),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_ram_i(cmd_ram), .cmd_a_i(cmd_a), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .r_w_o(r_w), .cs_o(cs), .rs_n_o(rs_n), .a_o(a),
    .d_out_o(d_out), .d_in_i(d_in), .irq_n_i(irq_n), .state_o(state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- peripheral model ----------------
  logic [7:0] ram [128];
  logic [7:0] io  [128];
  int  poll_seen = 0;
  int  flag_at = 0;
  logic use_irq = 1'b0;
  logic flag_cond;

  assign flag_cond = (flag_at != 0) && (poll_seen + 1 >= flag_at);
  assign irq_n = !(use_irq && flag_cond);
  assign d_in = !rs_n ? ram[a] :
                (a == 7'h05) ? {flag_cond & ~use_irq, 7'b0} : io[a];

  always @(posedge clk) begin
    if (cs == 2'b01 && r_w) begin
      poll_seen <= 0;
      if (rs_n) io[a] <= d_out;
      else      ram[a] <= d_out;
    end else if (cs == 2'b01 && rs_n && a == 7'h05) begin
      poll_seen <= poll_seen + 1;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_ram [128];
  logic [7:0]  exp_io  [128];
  logic [16:0] exp_bus_q[$];
  int          exp_bus_t_q[$];
  logic [8:0]  exp_q[$];
  int          exp_t_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  logic stall_req = 1'b0;
  int   stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  logic       prev_held = 1'b0;
  logic [8:0] prev_rsp = 9'h0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("cs_legal", 32'(cs == 2'b01 || cs == 2'b10), 32'd1);
      if (cs == 2'b10) check("r_w_idle", 32'(r_w), 32'd0);
      if (cs == 2'b01) begin
        if (exp_bus_q.size() == 0) begin
          check("spurious_bus", {15'd0, r_w, rs_n, a, d_out}, 32'h1FFFF);
        end else begin
          check("bus_cycle", {15'd0, r_w, rs_n, a, d_out}, {15'd0, exp_bus_q.pop_front()});
          check("bus_time", cyc, exp_bus_t_q.pop_front());
        end
      end
      if (rsp_valid) begin
        check("ready_in_resp", 32'(cmd_ready), 32'd0);
        if (prev_held) begin
          check("rsp_stable", {23'd0, rsp_err, rsp_data}, {23'd0, prev_rsp});
        end else if (exp_q.size() == 0) begin
          check("spurious_rsp", {23'd0, rsp_err, rsp_data}, 32'h1FF);
        end else begin
          check("rsp", {23'd0, rsp_err, rsp_data}, {23'd0, exp_q.pop_front()});
          check("rsp_time", cyc, exp_t_q.pop_front());
        end
        prev_held = !rsp_ready;
        prev_rsp  = {rsp_err, rsp_data};
      end else begin
        prev_held = 1'b0;
      end
    end
  end

  // rsp_ready driver: random back-pressure, plus a 10-cycle stall on request.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        rsp_ready = 1'b0;
        stall_cnt--;
      end else if (stall_req) begin
        rsp_ready = 1'b0;
        if (rsp_valid) begin
          stall_cnt = 9;
          stall_req = 1'b0;
        end
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic send(input logic [1:0] op, input logic ram_sel, input logic [6:0] addr,
                      input logic [7:0] data, input int fl, input logic irq);
    int n;
    int tp;
    int i;
    bit ok;
    logic [6:0] ta;
    logic err;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_ram = ram_sel; cmd_a = addr; cmd_data = data;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    n = cyc;
    flag_at = (op == 2'b10) ? fl : 0;
    use_irq = irq;
    case (op)
      2'b00: begin
        exp_bus_q.push_back({1'b1, ~ram_sel, addr, data}); exp_bus_t_q.push_back(n + 1);
        if (ram_sel) exp_ram[addr] = data; else exp_io[addr] = data;
        exp_q.push_back(9'h000); exp_t_q.push_back(n + 2);
      end
      2'b01: begin
        exp_bus_q.push_back({1'b0, ~ram_sel, addr, data}); exp_bus_t_q.push_back(n + 1);
        exp_q.push_back({1'b0, ram_sel ? exp_ram[addr] : exp_io[addr]});
        exp_t_q.push_back(n + 2);
      end
      2'b10: begin
        ta = 7'h14 | (addr & 7'h0B);
        exp_bus_q.push_back({1'b1, 1'b1, ta, data}); exp_bus_t_q.push_back(n + 1);
        exp_io[ta] = data;
        i = 0; err = 1'b0; tp = n + 1;
        forever begin
          i++;
          tp = n + 1 + i * (G + 1);
          exp_bus_q.push_back({1'b0, 1'b1, 7'h05, data}); exp_bus_t_q.push_back(tp);
          if (fl != 0 && i >= fl) begin err = 1'b0; break; end
          if (i * (G + 1) >= T) begin err = 1'b1; break; end
        end
        exp_q.push_back({err, 8'(i)}); exp_t_q.push_back(tp + 1);
      end
      default: begin
        exp_q.push_back(9'h100); exp_t_q.push_back(n + 1);
      end
    endcase
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_ram = 1'($urandom);
    cmd_a = 7'($urandom); cmd_data = 8'($urandom);
  endtask

  // Caller is just past a rising edge; reset is checked after the next edge.
  task automatic reset_and_check();
    res = 1'b1;
    cmd_valid = 1'b0;
    exp_bus_q.delete(); exp_bus_t_q.delete();
    exp_q.delete(); exp_t_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_cs", 32'(cs), 32'h2);
    check("rst_r_w", 32'(r_w), 32'd0);
    check("rst_rs_n", 32'(rs_n), 32'd1);
    check("rst_a", 32'(a), 32'd0);
    check("rst_d_out", 32'(d_out), 32'd0);
    check("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    res = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 500; k++) begin
      if (exp_q.size() == 0 && exp_bus_q.size() == 0) break;
      @(posedge clk);
    end
    if (k == 500) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] op;
    logic       rsel;
    logic [6:0] ad;
    for (int i = 0; i < 128; i++) begin
      ram[i] = 8'($urandom); io[i] = 8'($urandom);
      exp_ram[i] = ram[i];   exp_io[i] = io[i];
    end
    @(posedge clk); #1;
    reset_and_check();
    mon_en = 1'b1;

    send(2'b00, 1'b1, 7'h12, 8'hA5, 0, 1'b0);   // RAM write
    send(2'b00, 1'b0, 7'h00, 8'h3C, 0, 1'b0);   // I/O write to seed the read
    send(2'b01, 1'b0, 7'h00, 8'h77, 0, 1'b0);   // I/O read -> 3C
    send(2'b01, 1'b1, 7'h12, 8'h00, 0, 1'b0);   // RAM read back A5
    send(2'b10, 1'b0, 7'h09, 8'h05, 3, 1'b0);   // flag on 3rd poll
    send(2'b10, 1'b0, 7'h02, 8'h40, 0, 1'b0);   // never set -> timeout
    send(2'b10, 1'b1, 7'h0F, 8'h11, 2, 1'b1);   // IRQ_N on 2nd poll
    send(2'b10, 1'b0, 7'h00, 8'h22, 1, 1'b0);   // flag on first poll
    stall_req = 1'b1;
    send(2'b11, 1'b0, 7'h33, 8'h44, 0, 1'b0);   // reserved op, stalled response
    drain();

    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      rsel = 1'($urandom);
      ad = 7'($urandom);
      if (op == 2'b01 && !rsel && ad == 7'h05) ad = 7'h06;
      send(op, rsel, ad, 8'($urandom), $urandom_range(0, 5), 1'($urandom));
    end
    drain();

    send(2'b10, 1'b0, 7'h01, 8'h99, 0, 1'b0);
    @(posedge clk); #1;                          // now in GAP
    reset_and_check();
    repeat (12) @(posedge clk);                  // any stray bus/rsp is flagged
    send(2'b01, 1'b1, 7'h12, 8'h00, 0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "global timeout");
  end

endmodule
